// File: rtl/thermostat_pkg.sv
// Shared definitions for the thermostat setpoint controller: control FSM
// encoding, default setpoint limits and the comparison width.
package thermostat_pkg;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_HEAT = 2'd2,
      ST_COOL = 2'd3
   } ctrl_state_t;

   localparam int SP_RESET_DEF = 22;
   localparam int SP_MIN_DEF   = 10;
   localparam int SP_MAX_DEF   = 35;

   // Two guard bits above the 8-bit temperature so setpoint +/- HYST never wraps.
   localparam int CMP_W = 10;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stability counter; the accepted level
// follows the synchronised input once it has differed for DEBOUNCE_CYCLES cycles.
module button_debounce
   import thermostat_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic main_clk,
   input  logic rst_n,
   input  logic button,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
      end else begin
         sync_p0 <= button;
         sync_p1 <= sync_p0;
         // Any return to the accepted level restarts the stability window.
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_p1;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/thermostat_setpoint_ctrl.sv
// Thermostat setpoint controller: debounced up/down buttons with auto-repeat
// drive a saturating setpoint; a hysteresis FSM derives heat/cool demand.
module thermostat_setpoint_ctrl
   import thermostat_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000,
   parameter int SP_RESET        = SP_RESET_DEF,
   parameter int SP_MIN          = SP_MIN_DEF,
   parameter int SP_MAX          = SP_MAX_DEF,
   parameter int HYST            = 1
) (
   input  logic              main_clk,
   input  logic              rst_n,
   input  logic              buttonUp,
   input  logic              buttonDown,
   input  logic signed [7:0] temp_c,
   input  logic              temp_valid,
   output logic signed [7:0] setpoint,
   output logic              sp_changed,
   output logic              heat_on,
   output logic              cool_on
);

   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic signed [CMP_W-1:0] SP_MIN_W = CMP_W'(SP_MIN);
   localparam logic signed [CMP_W-1:0] SP_MAX_W = CMP_W'(SP_MAX);
   localparam logic signed [CMP_W-1:0] HYST_W   = CMP_W'(HYST);

   // Index 0 is the up button, index 1 the down button.
   logic [1:0]             lvl;
   logic [1:0]             lvl_q;
   logic [1:0]             rep_q;
   logic [1:0]             rise;
   logic [1:0]             tick;
   logic [1:0]             step;
   logic [1:0][HOLD_W-1:0] hold_cnt;
   logic                   both;

   logic signed [7:0]       sp_nxt;
   logic signed [CMP_W-1:0] temp_w;
   logic signed [CMP_W-1:0] sp_w;
   ctrl_state_t             state_q;
   ctrl_state_t             state_d;

   function automatic logic signed [7:0] step_sat(input logic signed [7:0] sp,
                                                  input logic up,
                                                  input logic dn);
      logic signed [CMP_W-1:0] nxt;
      nxt = {{(CMP_W-8){sp[7]}}, sp};
      if (up) begin
         nxt = nxt + 10'sd1;
      end else if (dn) begin
         nxt = nxt - 10'sd1;
      end
      if (nxt > SP_MAX_W) begin
         nxt = SP_MAX_W;
      end else if (nxt < SP_MIN_W) begin
         nxt = SP_MIN_W;
      end
      return nxt[7:0];
   endfunction

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .main_clk (main_clk),
      .rst_n    (rst_n),
      .button   (buttonUp),
      .level    (lvl[0])
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .main_clk (main_clk),
      .rst_n    (rst_n),
      .button   (buttonDown),
      .level    (lvl[1])
   );

   assign both = lvl[0] & lvl[1];

   // The hold counter measures REPEAT_DELAY before the first repeat, then REPEAT_PERIOD.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rise[i] = lvl[i] & ~lvl_q[i];
         tick[i] = rep_q[i] ? (hold_cnt[i] == HOLD_W'(REPEAT_PERIOD))
                            : (hold_cnt[i] == HOLD_W'(REPEAT_DELAY));
         step[i] = (rise[i] | (lvl[i] & tick[i])) & ~both;
      end
   end

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q    <= '0;
         rep_q    <= '0;
         hold_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            lvl_q[i] <= lvl[i];
            if (!lvl[i] || both) begin
               hold_cnt[i] <= '0;
               rep_q[i]    <= 1'b0;
            end else if (tick[i]) begin
               hold_cnt[i] <= HOLD_W'(1);
               rep_q[i]    <= 1'b1;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign sp_nxt = step_sat(setpoint, step[0], step[1]);

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         setpoint   <= 8'(SP_RESET);
         sp_changed <= 1'b0;
      end else begin
         setpoint   <= sp_nxt;
         sp_changed <= (sp_nxt != setpoint);
      end
   end

   assign temp_w = {{(CMP_W-8){temp_c[7]}}, temp_c};
   assign sp_w   = {{(CMP_W-8){setpoint[7]}}, setpoint};

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // WAIT evaluates its first sample with the IDLE rules; HEAT and COOL only exit via IDLE.
   always_comb begin
      state_d = state_q;
      if (temp_valid) begin
         case (state_q)
            ST_WAIT, ST_IDLE: begin
               if (temp_w < sp_w - HYST_W) begin
                  state_d = ST_HEAT;
               end else if (temp_w > sp_w + HYST_W) begin
                  state_d = ST_COOL;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HEAT: if (temp_w >= sp_w) state_d = ST_IDLE;
            ST_COOL: if (temp_w <= sp_w) state_d = ST_IDLE;
            default: state_d = ST_WAIT;
         endcase
      end
   end

   always_comb begin
      heat_on = (state_q == ST_HEAT);
      cool_on = (state_q == ST_COOL);
   end

endmodule
